// File: rtl/softmax_job_sched_pkg.sv
// Shared definitions for the softmax job scheduler.
//   sched_state_e : scheduler FSM state encoding (also visible on dbg_state)
//   ERR_*         : completion status codes reported on cmpl_err
package softmax_job_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_INIT  = 3'd2,
    ST_START = 3'd3,
    ST_MAX   = 3'd4,
    ST_TAIL  = 3'd5,
    ST_FLUSH = 3'd6,
    ST_COMPL = 3'd7
  } sched_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_EMPTY   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_LEN     = 2'b11;

endpackage

// File: rtl/softmax_job_sched_desc_fifo.sv
// Descriptor queue for the softmax job scheduler.
// Synchronous show-ahead FIFO: dout always presents the oldest entry while
// empty is low, so the consumer can latch it in the same cycle it pops.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (pointers only)
//   push, din    : write an entry (ignored when full unless popping too)
//   pop, dout    : remove the oldest entry / oldest entry contents
//   full, empty  : occupancy flags
module softmax_job_sched_desc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit separates the full and empty cases.
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A push into a full queue is accepted when a pop frees a slot in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign dout = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/softmax_job_sched.sv
// Job scheduler for the softmax engine.
// Queues vector descriptors, launches one softmax run per descriptor
// (sm_init then sm_start), holds the source range stable for the whole run,
// generates result-write addresses while the engine streams outputs and
// reports a completion status per job.
// Ports:
//   clk, reset_n                    : clock, asynchronous active-low reset
//   req_valid/req_ready             : descriptor handshake
//   req_start_addr/end_addr/dst/id  : descriptor fields (end is exclusive)
//   timeout_cycles                  : watchdog limit for MAX+TAIL, 0 disables
//   sm_init/sm_start/sm_reset       : control pulses / flush to softmax
//   sm_start_addr/sm_end_addr       : source range held for the running job
//   sm_mode1_done, sm_done          : softmax max-pass done / output valid
//   wr_en, wr_addr                  : result write strobe and address
//   cmpl_valid/cmpl_id/cmpl_err     : 1-cycle completion report
//   busy                            : FSM active or descriptors pending
//   dbg_state                       : current FSM state
//
// Handshake: a descriptor is transferred on every rising clk edge where
// req_valid and req_ready are both high. req_ready depends only on queue
// occupancy (never on req_valid); a requester holding req_valid while
// req_ready is low must keep the descriptor fields stable.
module softmax_job_sched
  import softmax_job_sched_pkg::*;
#(
  parameter int ADDRW      = 16,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDRW-1:0] req_start_addr,
  input  logic [ADDRW-1:0] req_end_addr,
  input  logic [ADDRW-1:0] req_dst_addr,
  input  logic [ID_W-1:0]  req_id,
  input  logic [TO_W-1:0]  timeout_cycles,
  output logic             sm_init,
  output logic             sm_start,
  output logic             sm_reset,
  output logic [ADDRW-1:0] sm_start_addr,
  output logic [ADDRW-1:0] sm_end_addr,
  input  logic             sm_mode1_done,
  input  logic             sm_done,
  output logic             wr_en,
  output logic [ADDRW-1:0] wr_addr,
  output logic             cmpl_valid,
  output logic [ID_W-1:0]  cmpl_id,
  output logic [1:0]       cmpl_err,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int DW = 3*ADDRW + ID_W;

  sched_state_e     state_q, state_d;
  logic             pop_c;

  logic [DW-1:0]    fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty, fifo_push;

  logic [ADDRW-1:0] start_q, end_q, dst_q;
  logic [ID_W-1:0]  id_q;
  logic [1:0]       err_q;
  logic [TO_W-1:0]  wdog_q, wdog_inc;
  logic [ADDRW-1:0] wcnt_q, wcnt_sat, len;
  logic             wr_en_q;
  logic [ADDRW-1:0] wr_addr_q;
  logic             sm_done_q;
  logic             flush_cnt_q;
  logic             range_empty, done_fall, timeout_hit;

  // ------------------------------------------------------------------
  // Descriptor queue
  // ------------------------------------------------------------------
  assign fifo_din  = {req_start_addr, req_end_addr, req_dst_addr, req_id};
  assign req_ready = ~fifo_full;
  assign fifo_push = req_valid & req_ready;

  softmax_job_sched_desc_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (pop_c),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ------------------------------------------------------------------
  // Datapath helpers
  // ------------------------------------------------------------------
  assign range_empty = (end_q <= start_q);
  assign len         = end_q - start_q;
  assign done_fall   = sm_done_q & ~sm_done;
  assign timeout_hit = (timeout_cycles != '0) && (wdog_q >= timeout_cycles);
  assign wdog_inc    = (&wdog_q) ? wdog_q : wdog_q + TO_W'(1);
  assign wcnt_sat    = (&wcnt_q) ? wcnt_q : wcnt_q + ADDRW'(1);

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: state_d = range_empty ? ST_COMPL : ST_INIT;
      ST_INIT:  state_d = ST_START;
      ST_START: state_d = ST_MAX;
      ST_MAX: begin
        if (timeout_hit)        state_d = ST_FLUSH;
        else if (sm_mode1_done) state_d = ST_TAIL;
      end
      ST_TAIL: begin
        // Timeout has priority over a same-cycle end of the output stream.
        if (timeout_hit)    state_d = ST_FLUSH;
        else if (done_fall) state_d = ST_COMPL;
      end
      ST_FLUSH: begin
        if (flush_cnt_q) state_d = ST_COMPL;
      end
      ST_COMPL: begin
        // Chain straight into the next descriptor so back-to-back jobs
        // reach CHECK one cycle after the completion pulse.
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Descriptor latch, watchdog, write counter, status
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q     <= '0;
      end_q       <= '0;
      dst_q       <= '0;
      id_q        <= '0;
      err_q       <= ERR_OK;
      wdog_q      <= '0;
      wcnt_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      sm_done_q   <= 1'b0;
      flush_cnt_q <= 1'b0;
    end else begin
      sm_done_q   <= sm_done;
      flush_cnt_q <= (state_q == ST_FLUSH);
      // Write strobe is sm_done delayed by one cycle, only for the running job.
      wr_en_q     <= (state_q == ST_TAIL) && sm_done;

      if (pop_c) {start_q, end_q, dst_q, id_q} <= fifo_dout;

      case (state_q)
        ST_CHECK: begin
          if (range_empty) err_q <= ERR_EMPTY;
        end
        ST_START: begin
          wdog_q <= '0;
          wcnt_q <= '0;
        end
        ST_MAX: wdog_q <= wdog_inc;
        ST_TAIL: begin
          wdog_q <= wdog_inc;
          if (sm_done) begin
            wr_addr_q <= dst_q + wcnt_q;
            wcnt_q    <= wcnt_sat;
          end
          if (done_fall && !timeout_hit)
            err_q <= (wcnt_q == len) ? ERR_OK : ERR_LEN;
        end
        ST_FLUSH: err_q <= ERR_TIMEOUT;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign sm_init       = (state_q == ST_INIT);
  assign sm_start      = (state_q == ST_START);
  // Softmax is held in reset for as long as the scheduler itself is.
  assign sm_reset      = ~reset_n | (state_q == ST_FLUSH);
  assign sm_start_addr = start_q;
  assign sm_end_addr   = end_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign cmpl_valid    = (state_q == ST_COMPL);
  assign cmpl_id       = id_q;
  assign cmpl_err      = err_q;
  assign busy          = (state_q != ST_IDLE) | ~fifo_empty;
  assign dbg_state     = state_q;

endmodule
